// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO pair.
// Shift-add multiply and restoring divide, 32 iterations plus a sign-fix cycle.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  mthi,
  input  logic                  mtlo,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;
  localparam logic [5:0] LAST_ITER = 6'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} stateT;

  stateT          state;
  logic [2*W-1:0] acc;
  logic [W-1:0]   operandB;
  logic [5:0]     count;
  logic           isDiv;
  logic           negResult;
  logic           negRem;
  logic           divZero;

  logic [W-1:0]   rsMag;
  logic [W-1:0]   rtMag;
  logic [W:0]     mulSum;
  logic [2*W-1:0] mulNext;
  logic [W:0]     divShift;
  logic [W-1:0]   divDiff;
  logic           noBorrow;
  logic [2*W-1:0] divNext;
  logic [2*W-1:0] product;
  logic [W-1:0]   quoOut;
  logic [W-1:0]   remOut;

  // For multiply, acc = {partial product, remaining multiplier bits}; for divide,
  // acc = {partial remainder, dividend bits shifting into quotient bits}.
  always_comb begin
    rsMag    = (!op[0] && rs_data[W-1]) ? (W'(0) - rs_data) : rs_data;
    rtMag    = (!op[0] && rt_data[W-1]) ? (W'(0) - rt_data) : rt_data;

    mulSum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operandB} : {(W+1){1'b0}});
    mulNext  = {mulSum, acc[W-1:1]};

    divShift = {acc[2*W-1:W], acc[W-1]};
    noBorrow = (divShift >= {1'b0, operandB});
    divDiff  = divShift[W-1:0] - operandB;
    divNext  = {(noBorrow ? divDiff : divShift[W-1:0]), acc[W-2:0], noBorrow};

    product  = negResult ? ((2*W)'(0) - acc) : acc;
    quoOut   = negResult ? (W'(0) - acc[W-1:0]) : acc[W-1:0];
    remOut   = negRem ? (W'(0) - acc[2*W-1:W]) : acc[2*W-1:W];
  end

  // Control FSM and datapath registers; HI/LO only change on moves or in SIGN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      acc       <= '0;
      operandB  <= '0;
      count     <= '0;
      isDiv     <= 1'b0;
      negResult <= 1'b0;
      negRem    <= 1'b0;
      divZero   <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            isDiv     <= op[1];
            negResult <= !op[0] && (rs_data[W-1] ^ rt_data[W-1]);
            negRem    <= !op[0] && op[1] && rs_data[W-1];
            divZero   <= op[1] && (rt_data == '0);
            operandB  <= op[1] ? rtMag : rsMag;
            acc       <= {{W{1'b0}}, (op[1] ? rsMag : rtMag)};
            count     <= '0;
            busy      <= 1'b1;
            state     <= CALC;
          end else begin
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
          end
        end
        CALC: begin
          acc   <= isDiv ? divNext : mulNext;
          count <= count + 6'd1;
          if (count == LAST_ITER) state <= SIGN;
        end
        SIGN: begin
          if (!isDiv) begin
            hi <= product[2*W-1:W];
            lo <= product[W-1:0];
          end else if (!divZero) begin
            hi <= remOut;
            lo <= quoOut;
          end
          done     <= 1'b1;
          div_zero <= divZero;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner-case
// sequences, and random operations checked against an arithmetic reference.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vecT;

  vecT vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
  function automatic void modelOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    eh = modelHi;
    el = modelLo;
    edz = 1'b0;
    case (o)
      2'b00: begin q = sa * sb; eh = q[63:32]; el = q[31:0]; end
      2'b01: begin p = ua * ub; eh = p[63:32]; el = p[31:0]; end
      2'b10: begin
        if (b == 0) edz = 1'b1;
        else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      end
      default: begin
        if (b == 0) edz = 1'b1;
        else begin p = ua / ub; el = p[31:0]; p = ua % ub; eh = p[31:0]; end
      end
    endcase
  endfunction

  task automatic moveTo(input bit toHi, input bit toLo, input logic [31:0] v);
    @(negedge clk);
    mthi = toHi;
    mtlo = toLo;
    rs_data = v;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    if (toHi) modelHi = v;
    if (toLo) modelLo = v;
    checkOutput("move hi", hi, modelHi);
    checkOutput("move lo", lo, modelLo);
  endtask

  // Launches one op and follows it to done; optional disturbance or reset mid-op.
  task automatic applyStimulus(input string name, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                               input logic expDz, input int disturbAt, input int resetAt, input bit withMove);
    logic [31:0] prevHi, prevLo;
    int cycles;
    bit holdOk, busyOk, quietOk;
    prevHi = hi;
    prevLo = lo;
    holdOk = 1'b1;
    busyOk = 1'b1;
    @(negedge clk);
    start = 1'b1;
    op = o;
    rs_data = a;
    rt_data = b;
    mthi = withMove;
    mtlo = withMove;
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    checkOutput({name, " busy after start"}, 32'(busy), 32'd1);
    cycles = 0;
    while (!done && cycles < 60) begin
      if (hi !== prevHi || lo !== prevLo) holdOk = 1'b0;
      if (busy !== 1'b1) busyOk = 1'b0;
      @(negedge clk);
      if (cycles == disturbAt) begin
        start = 1'b1;
        mthi = 1'b1;
        mtlo = 1'b1;
        rs_data = 32'hDEADBEEF;
      end
      if (cycles == resetAt) reset = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      mthi = 1'b0;
      mtlo = 1'b0;
      cycles++;
      if (reset) begin
        reset = 1'b0;
        modelHi = '0;
        modelLo = '0;
        checkOutput({name, " reset busy"}, 32'(busy), 32'd0);
        checkOutput({name, " reset done"}, 32'(done), 32'd0);
        checkOutput({name, " reset hi"}, hi, 32'd0);
        checkOutput({name, " reset lo"}, lo, 32'd0);
        quietOk = 1'b1;
        repeat (40) begin
          @(posedge clk);
          #1;
          if (done !== 1'b0) quietOk = 1'b0;
        end
        checkOutput({name, " no done after reset"}, 32'(quietOk), 32'd1);
        return;
      end
    end
    checkOutput({name, " latency"}, cycles, 32'd33);
    checkOutput({name, " hold during calc"}, 32'(holdOk), 32'd1);
    checkOutput({name, " busy during calc"}, 32'(busyOk), 32'd1);
    checkOutput({name, " done"}, 32'(done), 32'd1);
    checkOutput({name, " busy at done"}, 32'(busy), 32'd0);
    checkOutput({name, " div_zero"}, 32'(div_zero), 32'(expDz));
    checkOutput({name, " hi"}, hi, expHi);
    checkOutput({name, " lo"}, lo, expLo);
    modelHi = expHi;
    modelLo = expLo;
    if (disturbAt >= 0) begin
      @(posedge clk);
      #1;
      checkOutput({name, " single done"}, 32'(done), 32'd0);
      checkOutput({name, " not requeued"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic runModel(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int disturbAt, input int resetAt, input bit withMove);
    logic [31:0] eh, el;
    logic edz;
    modelOp(o, a, b, eh, el, edz);
    applyStimulus(name, o, a, b, eh, el, edz, disturbAt, resetAt, withMove);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vecs[0] = '{"multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult -3x7", 2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{"mult minxmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{"div -7/2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{"divu 7/2", 2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[5] = '{"div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{"div 7/-2", 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{"multu zero", 2'b01, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000};
    vecs[8] = '{"divu max/1", 2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[9] = '{"div -7/-2", 2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset div_zero", 32'(div_zero), 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].expHi, vecs[i].expLo, 1'b0, -1, -1, 1'b0);

    moveTo(1'b1, 1'b0, 32'h12345678);
    applyStimulus("divu by zero", 2'b11, 32'd5, 32'd0, 32'h12345678, modelLo, 1'b1, -1, -1, 1'b0);
    moveTo(1'b1, 1'b1, 32'hAABBCCDD);
    runModel("multu disturbed", 2'b01, 32'h00010003, 32'h00020005, 10, -1, 1'b0);
    runModel("start with move", 2'b00, 32'hFFFFFF00, 32'h00000123, -1, -1, 1'b1);
    runModel("div reset", 2'b10, 32'hFFFFFFF9, 32'd2, -1, 15, 1'b0);
    runModel("after reset", 2'b11, 32'd1000, 32'd7, -1, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) moveTo(1'($urandom), 1'($urandom), $urandom);
      runModel("random", 2'($urandom), pick(), pick(), -1, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
